// File: rtl/l2l1_msg_pkg.sv
// Shared message codes and helpers for the L2->L1 message queue.
package l2l1_msg_pkg;

  localparam int L2L1_MSG_W = 3;

  typedef enum logic [L2L1_MSG_W-1:0] {
    MSG_NONE           = 3'd0,
    MSG_GETLINE        = 3'd1,
    MSG_SENDLINE       = 3'd2,
    MSG_INVALIDATELINE = 3'd3,
    MSG_EVICTLINE      = 3'd4
  } l2l1_msg_e;

  function automatic logic is_legal_msg(input logic [L2L1_MSG_W-1:0] code);
    logic legal;
    case (code)
      MSG_GETLINE, MSG_SENDLINE, MSG_INVALIDATELINE, MSG_EVICTLINE: legal = 1'b1;
      default:                                                      legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/l2l1_msg_fifo.sv
// Generic synchronous FIFO: registered storage, wrapping pointers, occupancy, full/empty.
module l2l1_msg_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        do_push_s, do_pop_s;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/l2_l1_msg_queue.sv
// L2->L1 message queue: filters illegal codes, applies the normal-mode gate, buffers for the logger.
// Optional per-type pop statistics enabled by macro L2L1_MSG_STATS_EN.
module l2_l1_msg_queue
  import l2l1_msg_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     normal_mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [L2L1_MSG_W-1:0]    in_msg,
  input  logic [ADDR_W-1:0]        in_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [L2L1_MSG_W-1:0]    out_msg,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              err_cnt
`ifdef L2L1_MSG_STATS_EN
  ,
  output logic [15:0]              stat_get,
  output logic [15:0]              stat_send,
  output logic [15:0]              stat_inval,
  output logic [15:0]              stat_evict
`endif
);

  localparam int WIDTH = L2L1_MSG_W + ADDR_W;

  logic             full_s, empty_s;
  logic             push_hs_s, legal_s, fifo_push_s, pop_s;
  logic [WIDTH-1:0] rdata_s;
  logic [15:0]      err_cnt_q, err_cnt_d;

  // in_ready deliberately ignores a same-cycle pop when full.
  assign in_ready    = !full_s || !normal_mode;
  assign push_hs_s   = in_valid && in_ready;
  assign legal_s     = is_legal_msg(in_msg);
  assign fifo_push_s = push_hs_s && legal_s && normal_mode;
  assign out_valid   = !empty_s;
  assign pop_s       = out_valid && out_ready;
  assign {out_msg, out_addr} = rdata_s;
  assign err_cnt     = err_cnt_q;

  l2l1_msg_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .wdata ({in_msg, in_addr}),
    .pop   (pop_s),
    .rdata (rdata_s),
    .count (count),
    .full  (full_s),
    .empty (empty_s)
  );

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push_hs_s && !legal_s) begin
      err_cnt_d = sat_inc16(err_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef L2L1_MSG_STATS_EN
  logic [15:0] stat_get_q, stat_get_d;
  logic [15:0] stat_send_q, stat_send_d;
  logic [15:0] stat_inval_q, stat_inval_d;
  logic [15:0] stat_evict_q, stat_evict_d;

  // Only legal codes can reach the head, so the default arm never fires on a pop.
  always_comb begin
    stat_get_d   = stat_get_q;
    stat_send_d  = stat_send_q;
    stat_inval_d = stat_inval_q;
    stat_evict_d = stat_evict_q;
    if (pop_s) begin
      case (out_msg)
        MSG_GETLINE:        stat_get_d   = sat_inc16(stat_get_q);
        MSG_SENDLINE:       stat_send_d  = sat_inc16(stat_send_q);
        MSG_INVALIDATELINE: stat_inval_d = sat_inc16(stat_inval_q);
        MSG_EVICTLINE:      stat_evict_d = sat_inc16(stat_evict_q);
        default:            stat_get_d   = stat_get_q;
      endcase
    end else begin
      stat_get_d = stat_get_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_get_q   <= 16'd0;
      stat_send_q  <= 16'd0;
      stat_inval_q <= 16'd0;
      stat_evict_q <= 16'd0;
    end else begin
      stat_get_q   <= stat_get_d;
      stat_send_q  <= stat_send_d;
      stat_inval_q <= stat_inval_d;
      stat_evict_q <= stat_evict_d;
    end
  end

  assign stat_get   = stat_get_q;
  assign stat_send  = stat_send_q;
  assign stat_inval = stat_inval_q;
  assign stat_evict = stat_evict_q;
`endif

endmodule

// File: tb/tb_l2_l1_msg_queue.sv
// Scoreboard bench for l2_l1_msg_queue: stimulus pushes expected entries, a negedge monitor checks pops.
module tb_l2_l1_msg_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        normal_mode = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_msg = 3'd0;
  logic [31:0] in_addr = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_msg;
  logic [31:0] out_addr;
  logic [3:0]  count;
  logic [15:0] err_cnt;
`ifdef L2L1_MSG_STATS_EN
  logic [15:0] stat_get, stat_send, stat_inval, stat_evict;
  int          m_get = 0, m_send = 0, m_inval = 0, m_evict = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [34:0] sb[$];

  l2_l1_msg_queue #(.DEPTH(8), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .normal_mode (normal_mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_msg      (in_msg),
    .in_addr     (in_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_msg     (out_msg),
    .out_addr    (out_addr),
    .count       (count),
    .err_cnt     (err_cnt)
`ifdef L2L1_MSG_STATS_EN
    ,
    .stat_get    (stat_get),
    .stat_send   (stat_send),
    .stat_inval  (stat_inval),
    .stat_evict  (stat_evict)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [2:0] msg, input logic [31:0] addr, input bit enq);
    in_valid = 1'b1;
    in_msg   = msg;
    in_addr  = addr;
    if (enq) sb.push_back({msg, addr});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (count == 4'd0) break;
      tick();
    end
    chk("drain_done", {60'd0, count}, 64'd0);
  endtask

  // Monitor: a handshake visible at the negedge completes on the following posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got msg=%0d addr=0x%0h expected no output", out_msg, out_addr);
      end else begin
        logic [34:0] e;
        e = sb.pop_front();
        if ({out_msg, out_addr} !== e) begin
          n_fail++;
          $display("FAIL pop_data: got msg=%0d addr=0x%0h expected msg=%0d addr=0x%0h",
                   out_msg, out_addr, e[34:32], e[31:0]);
        end
`ifdef L2L1_MSG_STATS_EN
        case (e[34:32])
          3'd1: m_get++;
          3'd2: m_send++;
          3'd3: m_inval++;
          3'd4: m_evict++;
          default: ;
        endcase
`endif
      end
    end
  end

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    #2;
    chk("rst_count", {60'd0, count}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_msg", {61'd0, out_msg}, 64'd0);
    chk("rst_out_addr", {32'd0, out_addr}, 64'd0);
    chk("rst_err_cnt", {48'd0, err_cnt}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    #10 rst_n = 1'b1;
    tick();

    // 1: single push, one-cycle latency
    push_one(3'd1, 32'h1000, 1'b1);
    chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_out_msg", {61'd0, out_msg}, 64'd1);
    chk("t1_out_addr", {32'd0, out_addr}, 64'h1000);
    chk("t1_count", {60'd0, count}, 64'd1);
    out_ready = 1'b1;
    tick();
    chk("t1_count_after_pop", {60'd0, count}, 64'd0);
    out_ready = 1'b0;

    // 2: fill, hold off the ninth
    for (int i = 0; i < 8; i++) begin
      push_one(3'((i % 4) + 1), 32'h100 * (i + 1) + 32'(i), 1'b1);
    end
    chk("t2_count_full", {60'd0, count}, 64'd8);
    chk("t2_in_ready_full", {63'd0, in_ready}, 64'd0);
    chk("t2_head_stable_msg", {61'd0, out_msg}, 64'd1);
    in_valid = 1'b1;
    in_msg   = 3'd2;
    in_addr  = 32'hDEAD;
    tick();
    chk("t2_ninth_held", {60'd0, count}, 64'd8);
    chk("t2_head_stable_addr", {32'd0, out_addr}, 64'h100);

    // 3: full with push+pop -> only pop; push lands next cycle
    out_ready = 1'b1;
    tick();
    chk("t3_count_pop_only", {60'd0, count}, 64'd7);
    chk("t3_in_ready", {63'd0, in_ready}, 64'd1);
    sb.push_back({3'd2, 32'hDEAD});
    tick();
    chk("t3_count_push_pop", {60'd0, count}, 64'd7);
    in_valid = 1'b0;
    wait_empty(40);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);
    out_ready = 1'b0;

    // 4: illegal codes
    push_one(3'd0, 32'h11, 1'b0);
    chk("t4_valid_0", {63'd0, out_valid}, 64'd0);
    push_one(3'd5, 32'h22, 1'b0);
    chk("t4_valid_5", {63'd0, out_valid}, 64'd0);
    push_one(3'd7, 32'h33, 1'b0);
    chk("t4_valid_7", {63'd0, out_valid}, 64'd0);
    chk("t4_err_cnt", {48'd0, err_cnt}, 64'd3);
    chk("t4_count", {60'd0, count}, 64'd0);

    // 5: normal_mode off with entries queued
    push_one(3'd1, 32'hA0, 1'b1);
    push_one(3'd3, 32'hA4, 1'b1);
    push_one(3'd4, 32'hA8, 1'b1);
    normal_mode = 1'b0;
    push_one(3'd4, 32'h2000, 1'b0);
    chk("t5_discard_count", {60'd0, count}, 64'd3);
    push_one(3'd6, 32'h44, 1'b0);
    chk("t5_err_cnt_gated", {48'd0, err_cnt}, 64'd4);
    out_ready = 1'b1;
    wait_empty(20);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);
    out_ready = 1'b0;
    normal_mode = 1'b1;

    // 6: async reset mid-drain
    push_one(3'd1, 32'hB0, 1'b1);
    push_one(3'd2, 32'hB4, 1'b1);
    push_one(3'd4, 32'hB8, 1'b1);
    out_ready = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    sb.delete();
`ifdef L2L1_MSG_STATS_EN
    m_get = 0; m_send = 0; m_inval = 0; m_evict = 0;
`endif
    #1;
    chk("t6_valid_rst", {63'd0, out_valid}, 64'd0);
    chk("t6_count_rst", {60'd0, count}, 64'd0);
    chk("t6_err_rst", {48'd0, err_cnt}, 64'd0);
    #4 rst_n = 1'b1;
    tick();
    out_ready = 1'b0;

`ifdef L2L1_MSG_STATS_EN
    push_one(3'd1, 32'hC0, 1'b1);
    push_one(3'd4, 32'hC4, 1'b1);
    push_one(3'd1, 32'hC8, 1'b1);
    out_ready = 1'b1;
    wait_empty(20);
    chk("stat_get", {48'd0, stat_get}, 64'(m_get));
    chk("stat_get_2", {48'd0, stat_get}, 64'd2);
    chk("stat_evict", {48'd0, stat_evict}, 64'd1);
    chk("stat_send", {48'd0, stat_send}, 64'd0);
    out_ready = 1'b0;
`endif

    tick();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
